// File: rtl/fma_round_pkg.sv
// Shared types, flag bit positions and format constants for the FMA rounding stage.
package fma_round_pkg;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } round_mode_e;

    localparam int FLAG_W         = 5;
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Magnitudes below exclude the sign bit; callers slice the low ne+nf bits.
    function automatic logic [63:0] fp_max_norm(input int ne, input int nf);
        logic [63:0] e_max;
        e_max = (64'd1 << ne) - 64'd2;
        return (e_max << nf) | ((64'd1 << nf) - 64'd1);
    endfunction

    function automatic logic [63:0] fp_inf(input int ne, input int nf);
        return ((64'd1 << ne) - 64'd1) << nf;
    endfunction

    function automatic logic [63:0] fp_qnan(input int ne, input int nf);
        return fp_inf(ne, nf) | (64'd1 << (nf - 1));
    endfunction

endpackage

// File: rtl/fma_round_core.sv
// Combinational rounding: increment decision, mantissa carry, overflow saturation and specials.
module fma_round_core
    import fma_round_pkg::*;
#(
    parameter int NE = 5,
    parameter int NF = 10
) (
    input  logic              rnd_sign,
    input  logic [NE:0]       rnd_exp,
    input  logic [NF+2:0]     rnd_mant,
    input  logic              rnd_sticky,
    input  logic              rnd_nan,
    input  logic              rnd_inf,
    input  logic              rnd_invalid,
    input  round_mode_e       rnd_rm,
    output logic [NE+NF:0]    rnd_result,
    output logic [FLAG_W-1:0] rnd_flags
);

    localparam logic [63:0]      MAX_NORM_W = fp_max_norm(NE, NF);
    localparam logic [63:0]      INF_W      = fp_inf(NE, NF);
    localparam logic [63:0]      QNAN_W     = fp_qnan(NE, NF);
    localparam logic [NE+NF-1:0] MAX_NORM   = MAX_NORM_W[NE+NF-1:0];
    localparam logic [NE+NF-1:0] INF_MAG    = INF_W[NE+NF-1:0];
    localparam logic [NE+NF-1:0] QNAN_MAG   = QNAN_W[NE+NF-1:0];
    localparam int               EXP_TOP    = (1 << NE) - 1;
    localparam logic [NE+1:0]    EXP_OVF    = EXP_TOP[NE+1:0];

    logic          lsb;
    logic          guard_bit;
    logic          sticky_all;
    logic          inexact_raw;
    logic          inc;
    logic          promote;
    logic          overflow;
    logic          sat_inf;
    logic [NF+1:0] sig_sum;
    logic [NE+1:0] exp_rnd;

    // Round the significand, fold carries into the exponent, then override for overflow and specials.
    always_comb begin
        lsb         = rnd_mant[2];
        guard_bit   = rnd_mant[1];
        sticky_all  = rnd_mant[0] | rnd_sticky;
        inexact_raw = guard_bit | sticky_all;

        inc = 1'b0;
        case (rnd_rm)
            RM_RZ:   inc = 1'b0;
            RM_RNE:  inc = guard_bit & (lsb | sticky_all);
            RM_RDN:  inc = rnd_sign & inexact_raw;
            RM_RUP:  inc = ~rnd_sign & inexact_raw;
            default: inc = 1'b0;
        endcase

        // Top bit is a carry out of the hidden bit (normal case); bit NF is the hidden bit
        // itself, which a subnormal reaches only by rounding up into the normal range.
        sig_sum = {1'b0, rnd_mant[NF+2:2]} + {{(NF+1){1'b0}}, inc};
        promote = (rnd_exp == '0) & sig_sum[NF];
        exp_rnd = {1'b0, rnd_exp} + {{(NE+1){1'b0}}, sig_sum[NF+1]}
                                  + {{(NE+1){1'b0}}, promote};
        overflow = (exp_rnd >= EXP_OVF);

        rnd_result                 = {rnd_sign, exp_rnd[NE-1:0], sig_sum[NF-1:0]};
        rnd_flags                  = '0;
        rnd_flags[FLAG_INVALID]    = rnd_invalid;
        rnd_flags[FLAG_INEXACT]    = inexact_raw;
        rnd_flags[FLAG_UNDERFLOW]  = inexact_raw & (exp_rnd == '0);

        sat_inf = 1'b0;
        if (overflow) begin
            case (rnd_rm)
                RM_RNE:  sat_inf = 1'b1;
                RM_RZ:   sat_inf = 1'b0;
                RM_RUP:  sat_inf = ~rnd_sign;
                RM_RDN:  sat_inf = rnd_sign;
                default: sat_inf = 1'b1;
            endcase
            rnd_result                = {rnd_sign, sat_inf ? INF_MAG : MAX_NORM};
            rnd_flags[FLAG_OVERFLOW]  = 1'b1;
            rnd_flags[FLAG_INEXACT]   = 1'b1;
            rnd_flags[FLAG_UNDERFLOW] = 1'b0;
        end

        // NaN beats infinity; neither carries rounding flags.
        if (rnd_nan) begin
            rnd_result              = {1'b0, QNAN_MAG};
            rnd_flags               = '0;
            rnd_flags[FLAG_INVALID] = rnd_invalid;
        end else if (rnd_inf) begin
            rnd_result              = {rnd_sign, INF_MAG};
            rnd_flags               = '0;
            rnd_flags[FLAG_INVALID] = rnd_invalid;
        end
    end

endmodule

// File: rtl/fma_round_pipe.sv
// Two-stage valid/ready rounding pipeline: s1 holds the unrounded operand, s2 the rounded result.
module fma_round_pipe
    import fma_round_pkg::*;
#(
    parameter int NE   = 5,
    parameter int NF   = 10,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [NE:0]       in_exp,
    input  logic [NF+2:0]     in_mant,
    input  logic              in_sticky,
    input  logic              in_nan,
    input  logic              in_inf,
    input  logic              in_invalid,
    input  logic [1:0]        in_rm,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NE+NF:0]    out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [TAGW-1:0]   out_tag
);

    logic              s1_valid_q,   s1_valid_d;
    logic              s1_sign_q,    s1_sign_d;
    logic [NE:0]       s1_exp_q,     s1_exp_d;
    logic [NF+2:0]     s1_mant_q,    s1_mant_d;
    logic              s1_sticky_q,  s1_sticky_d;
    logic              s1_nan_q,     s1_nan_d;
    logic              s1_inf_q,     s1_inf_d;
    logic              s1_invalid_q, s1_invalid_d;
    round_mode_e       s1_rm_q,      s1_rm_d;
    logic [TAGW-1:0]   s1_tag_q,     s1_tag_d;

    logic              s2_valid_q,   s2_valid_d;
    logic [NE+NF:0]    s2_result_q,  s2_result_d;
    logic [FLAG_W-1:0] s2_flags_q,   s2_flags_d;
    logic [TAGW-1:0]   s2_tag_q,     s2_tag_d;

    logic              s1_ready;
    logic              s2_ready;
    logic [NE+NF:0]    core_result;
    logic [FLAG_W-1:0] core_flags;

    fma_round_core #(
        .NE (NE),
        .NF (NF)
    ) u_core (
        .rnd_sign    (s1_sign_q),
        .rnd_exp     (s1_exp_q),
        .rnd_mant    (s1_mant_q),
        .rnd_sticky  (s1_sticky_q),
        .rnd_nan     (s1_nan_q),
        .rnd_inf     (s1_inf_q),
        .rnd_invalid (s1_invalid_q),
        .rnd_rm      (s1_rm_q),
        .rnd_result  (core_result),
        .rnd_flags   (core_flags)
    );

    // Handshake and next-state: a stage loads when it is empty or its content moves on.
    // Payload registers only change on a real load, so s2 outputs hold steady under stall.
    always_comb begin
        s2_ready = ~s2_valid_q | out_ready;
        s1_ready = ~s1_valid_q | s2_ready;

        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_mant_d    = s1_mant_q;
        s1_sticky_d  = s1_sticky_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        s1_invalid_d = s1_invalid_q;
        s1_rm_d      = s1_rm_q;
        s1_tag_d     = s1_tag_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_flags_d   = s2_flags_q;
        s2_tag_d     = s2_tag_q;

        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d    = in_sign;
                s1_exp_d     = in_exp;
                s1_mant_d    = in_mant;
                s1_sticky_d  = in_sticky;
                s1_nan_d     = in_nan;
                s1_inf_d     = in_inf;
                s1_invalid_d = in_invalid;
                s1_rm_d      = round_mode_e'(in_rm);
                s1_tag_d     = in_tag;
            end
        end

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
                s2_tag_d    = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset empties both stages and clears the visible outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_mant_q    <= '0;
            s1_sticky_q  <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_invalid_q <= 1'b0;
            s1_rm_q      <= RM_RZ;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_flags_q   <= '0;
            s2_tag_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_mant_q    <= s1_mant_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_nan_q     <= s1_nan_d;
            s1_inf_q     <= s1_inf_d;
            s1_invalid_q <= s1_invalid_d;
            s1_rm_q      <= s1_rm_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
            s2_tag_q     <= s2_tag_d;
        end
    end

    assign in_ready   = s1_ready;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;
    assign out_tag    = s2_tag_q;

endmodule

// File: tb/tb_fma_round_pipe.sv
// Self-checking bench for fma_round_pipe (fp16 configuration) with a queue-based reference model.
module tb_fma_round_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [5:0]  in_exp = '0;
    logic [12:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_invalid = 1'b0;
    logic [1:0]  in_rm = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;

    fma_round_pipe #(.NE(5), .NF(10), .TAGW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_nan     (in_nan),
        .in_inf     (in_inf),
        .in_invalid (in_invalid),
        .in_rm      (in_rm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sign;
        bit [5:0] exp;
        bit [12:0] mant;
        bit       sticky;
        bit       nan;
        bit       inf;
        bit       invalid;
        bit [1:0] rm;
        bit [3:0] tag;
    } op_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ready_pct = 100;
    bit   lat_chk = 1'b0;
    bit   bp_on = 1'b0;
    int   bp_base = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference rounding on integer significands: round, renormalise, then saturate.
    function automatic void model(input op_t op, output logic [15:0] r, output logic [4:0] f);
        int sig, e;
        bit g, st, lsb, inx, inc, to_inf;
        logic [4:0] e5;
        logic [9:0] fr;
        g   = op.mant[1];
        st  = op.mant[0] | op.sticky;
        lsb = op.mant[2];
        inx = g | st;
        case (op.rm)
            2'b00:   inc = 0;
            2'b01:   inc = g && (lsb || st);
            2'b10:   inc = op.sign && inx;
            default: inc = !op.sign && inx;
        endcase
        sig = int'(op.mant[12:2]) + int'(inc);
        e   = int'(op.exp);
        if (e == 0) begin
            if (sig >= 1024) e = 1;
        end else if (sig >= 2048) begin
            sig = sig / 2;
            e   = e + 1;
        end
        f = 5'b0;
        if (op.nan) begin
            r = 16'h7E00;
        end else if (op.inf) begin
            r = {op.sign, 15'h7C00};
        end else if (e >= 31) begin
            case (op.rm)
                2'b00:   to_inf = 0;
                2'b01:   to_inf = 1;
                2'b10:   to_inf = op.sign;
                default: to_inf = !op.sign;
            endcase
            r = {op.sign, to_inf ? 15'h7C00 : 15'h7BFF};
            f[2] = 1'b1;
            f[0] = 1'b1;
        end else begin
            e5 = e[4:0];
            fr = sig[9:0];
            r  = {op.sign, e5, fr};
            f[0] = inx;
            f[1] = inx && (e == 0);
        end
        f[4] = op.invalid;
    endfunction

    function automatic op_t mk(bit s, int e, bit h, int fr, bit g, bit rb, bit st,
                               int rm, bit nan, bit inf, bit inv, int tag);
        op_t o;
        logic [9:0] f10;
        f10       = fr[9:0];
        o.sign    = s;
        o.exp     = e[5:0];
        o.mant    = {h, f10, g, rb};
        o.sticky  = st;
        o.nan     = nan;
        o.inf     = inf;
        o.invalid = inv;
        o.rm      = rm[1:0];
        o.tag     = tag[3:0];
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  e;
        int  fr;
        e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(29, 40)) : int'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0:       fr = 10'h3FF;
            1:       fr = int'($urandom_range(0, 3));
            default: fr = int'($urandom_range(0, 1023));
        endcase
        o = mk($urandom_range(0, 1) == 1, e, e != 0, fr,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               int'($urandom_range(0, 3)), $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
        return o;
    endfunction

    task automatic set_ready();
        if (bp_on) out_ready = !((cyc - bp_base) >= 3 && (cyc - bp_base) <= 5);
        else       out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic observe();
        if (bp_on && (cyc - bp_base) == 3) chk("bp_in_ready_low", in_ready, 0);
        if (bp_on && (cyc - bp_base) == 6) chk("bp_in_ready_high", in_ready, 1);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                chk("result", out_result, q[0].res);
                chk("flags", out_flags, q[0].flg);
                chk("tag", out_tag, q[0].tag);
                if (out_ready) begin
                    if (lat_chk) chk("latency", cyc - q[0].acc, 2);
                    void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        set_ready();
        #1 observe();
        tick();
    endtask

    task automatic send(input op_t op, input logic [15:0] er, input logic [4:0] ef);
        int  guard;
        bit  done;
        exp_t e;
        guard      = 0;
        done       = 0;
        in_sign    = op.sign;
        in_exp     = op.exp;
        in_mant    = op.mant;
        in_sticky  = op.sticky;
        in_nan     = op.nan;
        in_inf     = op.inf;
        in_invalid = op.invalid;
        in_rm      = op.rm;
        in_tag     = op.tag;
        in_valid   = 1'b1;
        while (!done) begin
            set_ready();
            #1 observe();
            if (in_ready) begin
                e.res = er; e.flg = ef; e.tag = op.tag; e.acc = cyc;
                q.push_back(e);
                done = 1;
            end
            tick();
            guard++;
            if (!done && guard > 200) begin
                chk("send_timeout", in_ready, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_model(input op_t op);
        logic [15:0] r;
        logic [4:0]  f;
        model(op, r, f);
        send(op, r, f);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            idle();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    typedef struct {
        op_t         op;
        logic [15:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Directed fp16 vectors: sign, exp, hidden, frac, g, r, sticky, rm, nan, inf, invalid, tag.
        vecs.push_back('{mk(0, 15, 1, 10'h001, 1, 0, 0, 1, 0, 0, 0, 0),  16'h3C02, 5'b00001});
        vecs.push_back('{mk(0, 15, 1, 10'h002, 1, 0, 0, 1, 0, 0, 0, 1),  16'h3C02, 5'b00001});
        vecs.push_back('{mk(0, 15, 1, 10'h3FF, 1, 0, 0, 3, 0, 0, 0, 2),  16'h4000, 5'b00001});
        vecs.push_back('{mk(0, 15, 1, 10'h3FF, 1, 0, 0, 0, 0, 0, 0, 3),  16'h3FFF, 5'b00001});
        vecs.push_back('{mk(0, 30, 1, 10'h3FF, 1, 0, 0, 1, 0, 0, 0, 4),  16'h7C00, 5'b00101});
        vecs.push_back('{mk(0, 30, 1, 10'h3FF, 1, 0, 0, 0, 0, 0, 0, 5),  16'h7BFF, 5'b00001});
        vecs.push_back('{mk(1, 30, 1, 10'h3FF, 1, 0, 0, 3, 0, 0, 0, 6),  16'hFBFF, 5'b00001});
        vecs.push_back('{mk(1, 30, 1, 10'h3FF, 1, 0, 0, 2, 0, 0, 0, 7),  16'hFC00, 5'b00101});
        vecs.push_back('{mk(0, 0,  0, 10'h3FF, 1, 0, 0, 1, 0, 0, 0, 8),  16'h0400, 5'b00001});
        vecs.push_back('{mk(0, 0,  0, 10'h001, 0, 0, 1, 0, 0, 0, 0, 9),  16'h0001, 5'b00011});
        vecs.push_back('{mk(0, 15, 1, 10'h000, 0, 0, 0, 3, 1, 0, 0, 10), 16'h7E00, 5'b00000});
        vecs.push_back('{mk(1, 15, 1, 10'h123, 1, 1, 1, 1, 0, 1, 0, 11), 16'hFC00, 5'b00000});
        vecs.push_back('{mk(1, 0,  0, 10'h000, 0, 0, 0, 1, 0, 0, 0, 12), 16'h8000, 5'b00000});
        vecs.push_back('{mk(0, 31, 1, 10'h000, 0, 0, 0, 1, 1, 1, 1, 13), 16'h7E00, 5'b10000});

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_flags", out_flags, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed vectors back-to-back at full throughput.
        ready_pct = 100;
        lat_chk   = 1'b1;
        foreach (vecs[i]) send(vecs[i].op, vecs[i].res, vecs[i].flg);
        drain();

        // Six ops with a three-cycle downstream stall.
        lat_chk = 1'b0;
        bp_on   = 1'b1;
        bp_base = cyc;
        for (int i = 0; i < 6; i++) begin
            op_t o;
            o = rand_op();
            o.tag = 4'(i);
            send_model(o);
        end
        drain();
        bp_on = 1'b0;

        // Reset with both stages occupied.
        ready_pct = 0;
        send_model(rand_op());
        send_model(rand_op());
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_result", out_result, 0);
        q.delete();
        #1 reset_n = 1'b1;
        @(negedge clk);
        cyc++;
        ready_pct = 100;
        lat_chk   = 1'b1;
        send_model(rand_op());
        drain();

        // Unstalled random stream: every op must show latency 2.
        for (int i = 0; i < 60; i++) send_model(rand_op());
        drain();

        // Random stream under random backpressure and input gaps.
        lat_chk   = 1'b0;
        ready_pct = 65;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            send_model(rand_op());
        end
        ready_pct = 100;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
